// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: canonical NOP, base opcodes and fetch-unit FSM states.
package riscv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] R_TYPE = 7'h33;
  localparam logic [6:0] I_TYPE = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6f;
  localparam logic [6:0] JALR   = 7'h67;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } ifu_state_t;

endpackage

// File: rtl/ifu_pc_gen.sv
// Fetch PC register, pending-redirect latch and +4 incrementer for instr_fetch_unit.
module ifu_pc_gen #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_redir,
  input  logic            load_pend,
  input  logic            take_pend,
  input  logic            advance,
  input  logic            clear_pend,
  input  logic [XLEN-1:0] redir_pc,
  output logic [XLEN-1:0] pc,
  output logic            pend_vld
);

  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] pc_plus4;

  // Wraps modulo 2^XLEN.
  assign pc_plus4 = pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      pend_pc  <= RESET_PC;
      pend_vld <= 1'b0;
    end else begin
      if (load_redir) begin
        pc       <= redir_pc;
        pend_vld <= 1'b0;
      end else if (load_pend) begin
        // The request address must stay stable until accepted, so park the target.
        pend_pc  <= redir_pc;
        pend_vld <= 1'b1;
      end else if (take_pend) begin
        pc       <= pend_pc;
        pend_vld <= 1'b0;
      end else if (advance) begin
        pc <= pc_plus4;
      end
      if (clear_pend) pend_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one-outstanding imem request FSM, instruction register and field slicing.
// Optional misaligned-redirect fault checking is enabled by defining IFU_MISALIGN_CHK_EN.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  // Request: transfer when imem_req_valid && imem_req_ready at a rising edge;
  // valid and addr stay stable until that edge. Response: one-cycle valid pulse.
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc_plus4,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            misaligned,
  output logic [2:0]      dbg_state
);

  ifu_state_t      state;
  logic            drop;
  logic [XLEN-1:0] pc;
  logic            pend_vld;
  logic [XLEN-1:0] redir_pc;
  logic            redir_bad;
  logic            load_redir, load_pend, take_pend, advance;

`ifdef IFU_MISALIGN_CHK_EN
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_pc  = redirect_pc;
`else
  assign redir_bad = 1'b0;
  assign redir_pc  = redirect_pc & ~XLEN'(3);
`endif

  always_comb begin
    load_redir = 1'b0;
    load_pend  = 1'b0;
    take_pend  = 1'b0;
    advance    = 1'b0;
    if (redirect_valid && !redir_bad) begin
      if (state == REQ && !imem_req_ready) load_pend  = 1'b1;
      else                                 load_redir = 1'b1;
    end else if (state == REQ && imem_req_ready && pend_vld) begin
      take_pend = 1'b1;
    end else if (state == HOLD && !redirect_valid && !stall) begin
      advance = 1'b1;
    end
  end

  ifu_pc_gen #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_redir (load_redir),
    .load_pend  (load_pend),
    .take_pend  (take_pend),
    .advance    (advance),
    .clear_pend (redir_bad),
    .redir_pc   (redir_pc),
    .pc         (pc),
    .pend_vld   (pend_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= NOP_INST;
      inst_pc    <= RESET_PC;
    end else if (redir_bad) begin
      state      <= FAULT;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= NOP_INST;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_req_ready) begin
            state <= WAIT;
            // The accepted request belongs to a stale path if any redirect is known.
            drop  <= redirect_valid || pend_vld;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            if (imem_resp_valid) begin
              state <= REQ;
              drop  <= 1'b0;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              inst       <= imem_resp_data;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_valid || !stall) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            state      <= REQ;
          end
        end
        FAULT: if (redirect_valid) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFU_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                misaligned <= 1'b0;
    else if (redir_bad)                        misaligned <= 1'b1;
    else if (state == FAULT && redirect_valid) misaligned <= 1'b0;
  end
`else
  assign misaligned = 1'b0;
`endif

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign inst_pc_plus4  = inst_pc + XLEN'(4);
  assign opcode         = inst[6:0];
  assign funct3         = inst[14:12];
  assign funct7         = inst[31:25];
  assign dbg_state      = state;

endmodule
